reg_file_rd2w1: RTL and testbench

- Architectural register file for the single-cycle core: 2 combinational read ports plus 1 clocked write port with enable.
- It is the read side of the processor's enabled-register state. It supplies rs1/rs2 operands to the ALU and branch unit, and accepts the writeback result once per cycle.
- Each register carries a "written since reset" flag. Verification and hazard-debug logic use these flags to detect reads of never-written registers.

---
 rtl/proc_pkg.sv | 14 +
 rtl/reg_file_rd_port.sv | 40 ++++
 rtl/reg_file_rd2w1.sv | 97 +++++++++
 tb/tb_reg_file_rd2w1.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: architectural widths, register-file address
// type and the hardwired-zero register index.
package proc_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: data/init mux, x0 forced
// to zero-and-initialised, optional write-to-read bypass (REGFILE_WRITE_BYPASS_EN).
module reg_file_rd_port
  import proc_pkg::*;
#(
  parameter int size   = XLEN,
  parameter int depth  = NREGS,
  parameter int addr_w = REG_ADDR_W
) (
  input  logic [size-1:0]   regs_i [depth],
  input  logic [depth-1:0]  init_i,
  input  logic [addr_w-1:0] addr_i,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic              we_i,
  input  logic [addr_w-1:0] wa_i,
  input  logic [size-1:0]   wd_i,
  input  logic              rst_i,
`endif
  output logic [size-1:0]   rd_o,
  output logic              rd_init_o
);

  always_comb begin
    rd_o      = regs_i[addr_i];
    rd_init_o = init_i[addr_i];
    if (addr_i == '0) begin
      rd_o      = '0;
      rd_init_o = 1'b1;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the write that lands on the coming edge; reset blocks it
    // because that write will be discarded.
    if (!rst_i && we_i && (wa_i != '0) && (wa_i == addr_i)) begin
      rd_o      = wd_i;
      rd_init_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/reg_file_rd2w1.sv
// Architectural register file: two combinational read ports, one clocked write
// port, per-register "written since reset" flags. Optional: REGFILE_WRITE_BYPASS_EN.
module reg_file_rd2w1
  import proc_pkg::*;
#(
  parameter int size   = XLEN,
  parameter int depth  = NREGS,
  parameter int addr_w = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [addr_w-1:0] a1,
  input  logic [addr_w-1:0] a2,
  input  logic [addr_w-1:0] a3,
  input  logic [size-1:0]   wd3,
  output logic [size-1:0]   rd1,
  output logic [size-1:0]   rd2,
  output logic              rd1_init,
  output logic              rd2_init
);

  // Register 0 has no storage; only entries 1..depth-1 are flops.
  logic [size-1:0]  regs_q [1:depth-1];
  logic [size-1:0]  regs_d [1:depth-1];
  logic [depth-1:1] init_q;
  logic [depth-1:1] init_d;

  logic [size-1:0]  rf_view [depth];
  logic [depth-1:0] init_view;

  always_comb begin
    regs_d = regs_q;
    init_d = init_q;
    if (we3 && (a3 != '0)) begin
      regs_d[a3] = wd3;
      init_d[a3] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < depth; i++) begin
        regs_q[i] <= '0;
      end
      init_q <= '0;
    end else begin
      regs_q <= regs_d;
      init_q <= init_d;
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < depth; i++) begin
      rf_view[i] = regs_q[i];
    end
    init_view = {init_q, 1'b1};
  end

  reg_file_rd_port #(
    .size   (size),
    .depth  (depth),
    .addr_w (addr_w)
  ) u_rd_port1 (
    .regs_i    (rf_view),
    .init_i    (init_view),
    .addr_i    (a1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .we_i      (we3),
    .wa_i      (a3),
    .wd_i      (wd3),
    .rst_i     (reset),
`endif
    .rd_o      (rd1),
    .rd_init_o (rd1_init)
  );

  reg_file_rd_port #(
    .size   (size),
    .depth  (depth),
    .addr_w (addr_w)
  ) u_rd_port2 (
    .regs_i    (rf_view),
    .init_i    (init_view),
    .addr_i    (a2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .we_i      (we3),
    .wa_i      (a3),
    .wd_i      (wd3),
    .rst_i     (reset),
`endif
    .rd_o      (rd2),
    .rd_init_o (rd2_init)
  );

endmodule

// File: tb/tb_reg_file_rd2w1.sv
// Scoreboard bench for reg_file_rd2w1: stimulus pushes expected read values,
// a negedge monitor pops and compares them against both read ports.
module tb_reg_file_rd2w1;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;
  logic        rd1_init, rd2_init;

  typedef struct {
    logic [31:0] r1;
    logic        i1;
    logic [31:0] r2;
    logic        i2;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  reg_file_rd2w1 dut (
    .clk      (clk),
    .reset    (reset),
    .we3      (we3),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .wd3      (wd3),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd1_init (rd1_init),
    .rd2_init (rd2_init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; the expectation describes the
  // outputs seen before the following edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1,
                      input logic [4:0] ra2, input logic [31:0] er1,
                      input logic ei1, input logic [31:0] er2,
                      input logic ei2, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    we3   = we;
    a3    = wa;
    wd3   = wd;
    a1    = ra1;
    a2    = ra2;
    e.r1 = er1; e.i1 = ei1; e.r2 = er2; e.i2 = ei2; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (rd1 !== e.r1) begin
          n_fail++;
          $display("FAIL %s rd1 got %h expected %h", e.name, rd1, e.r1);
        end
        n_chk++;
        if (rd1_init !== e.i1) begin
          n_fail++;
          $display("FAIL %s rd1_init got %b expected %b", e.name, rd1_init, e.i1);
        end
        n_chk++;
        if (rd2 !== e.r2) begin
          n_fail++;
          $display("FAIL %s rd2 got %h expected %h", e.name, rd2, e.r2);
        end
        n_chk++;
        if (rd2_init !== e.i2) begin
          n_fail++;
          $display("FAIL %s rd2_init got %b expected %b", e.name, rd2_init, e.i2);
        end
      end
    end
  end

  logic [31:0] exp_same;

  initial begin : stimulus
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    we3    = 1'b0;
    a1     = '0;
    a2     = '0;
    a3     = '0;
    wd3    = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_same = 32'hB;
`else
    exp_same = 32'hA;
`endif
    //   rst we  a3  wd3            a1  a2  rd1           i1  rd2           i2
    step(1, 0, 0,  32'h0,          5,  7,  32'h0,        0,  32'h0,        0, "reset");
    step(1, 1, 2,  32'hCAFE,       2,  0,  32'h0,        0,  32'h0,        1, "rst_collide_pre");
    step(0, 0, 0,  32'h0,          2,  6,  32'h0,        0,  32'h0,        0, "rst_collide_post");
    step(0, 1, 7,  32'h1234_5678,  8,  8,  32'h0,        0,  32'h0,        0, "w7_pre");
    step(0, 0, 0,  32'h0,          7,  8,  32'h12345678, 1,  32'h0,        0, "w7_read");
    step(0, 1, 0,  32'hFFFF_FFFF,  0,  0,  32'h0,        1,  32'h0,        1, "x0_pre");
    step(0, 0, 0,  32'h0,          0,  0,  32'h0,        1,  32'h0,        1, "x0_post");
    step(0, 1, 3,  32'hA,          7,  7,  32'h12345678, 1,  32'h12345678, 1, "w3_a");
    step(0, 1, 3,  32'hB,          3,  5,  exp_same,     1,  32'h0,        0, "rw_same");
    step(0, 0, 0,  32'h0,          3,  3,  32'hB,        1,  32'hB,        1, "rw_after");
    step(0, 0, 4,  32'h55,         4,  9,  32'h0,        0,  32'h0,        0, "gate_pre");
    step(0, 0, 4,  32'h55,         4,  9,  32'h0,        0,  32'h0,        0, "gate_post");
    step(0, 1, 4,  32'h55,         9,  9,  32'h0,        0,  32'h0,        0, "w4");
    step(0, 1, 9,  32'h99,         4,  7,  32'h55,       1,  32'h12345678, 1, "w9");
    step(0, 0, 0,  32'h0,          4,  9,  32'h55,       1,  32'h99,       1, "dual");
    step(0, 0, 0,  32'h0,          9,  9,  32'h99,       1,  32'h99,       1, "same_addr");
    step(0, 1, 9,  32'h77,         4,  4,  32'h55,       1,  32'h55,       1, "rewrite9");
    step(0, 0, 0,  32'h0,          9,  5,  32'h77,       1,  32'h0,        0, "last_wins");
    step(0, 1, 5,  32'hDEAD_BEEF,  9,  9,  32'h77,       1,  32'h77,       1, "w5");
    step(0, 0, 0,  32'h0,          5,  0,  32'hDEADBEEF, 1,  32'h0,        1, "r5");
    step(1, 0, 0,  32'h0,          5,  9,  32'h0,        0,  32'h0,        0, "async_rst");
    step(0, 0, 0,  32'h0,          9,  0,  32'h0,        0,  32'h0,        1, "post_rst");
    step(0, 0, 0,  32'h0,          7,  3,  32'h0,        0,  32'h0,        0, "post_rst_all");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
